// File: rtl/vector_mem_requester_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vector_mem_requester_pkg : shared request format, access types, FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
`ifndef FLIP_FLOP
`define FLIP_FLOP(q, d, rv) \
  always_ff @(posedge clk or negedge reset) begin \
    if (!reset) q <= (rv); \
    else        q <= (d); \
  end
`endif

package vector_mem_requester_pkg;

  localparam int ADDR_FIELD_WIDTH = 32;
  localparam int DATA_FIELD_WIDTH = 32;
  localparam int BYTE             = 8;
  localparam int CORE_ID_WIDTH    = 4;
  localparam int ACCESS_ID_WIDTH  = 8;

  typedef enum logic [1:0] {
    READ_REQ  = 2'd0,
    WRITE_REQ = 2'd1,
    READ_RSP  = 2'd2,
    WRITE_RSP = 2'd3
  } access_type_e;

  typedef struct packed {
    logic                             vld;
    logic [CORE_ID_WIDTH-1:0]         core_id;
    logic [ACCESS_ID_WIDTH-1:0]       access_id;
    access_type_e                     access_type;
    logic [ADDR_FIELD_WIDTH-1:0]      addr;
    logic [DATA_FIELD_WIDTH-1:0]      data;
    logic [DATA_FIELD_WIDTH/BYTE-1:0] byte_en;
  } request_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vmr_state_e;

endpackage
`default_nettype wire

// File: rtl/vector_mem_requester.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vector_mem_requester : strided vector load/store sequencer, one element/cycle
// Rev 1.0
// ----------------------------------------------------------------------------
module vector_mem_requester
  import vector_mem_requester_pkg::*;
#(
  parameter int unsigned CORE_ID = 0,
  parameter int unsigned VLEN    = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_vld,
  output logic                             cmd_rdy,
  input  logic                             cmd_store,
  input  logic [ADDR_FIELD_WIDTH-1:0]      cmd_base,
  input  logic [ADDR_FIELD_WIDTH-1:0]      cmd_stride,
  input  logic [$clog2(VLEN):0]            cmd_len,
  input  logic [DATA_FIELD_WIDTH/BYTE-1:0] cmd_byte_en,
  output logic [$clog2(VLEN)-1:0]          st_idx,
  input  logic [DATA_FIELD_WIDTH-1:0]      st_data,
  output request_t                         mem_req,
  input  request_t                         mem_rsp,
  output logic                             ld_vld,
  output logic [$clog2(VLEN)-1:0]          ld_idx,
  output logic [DATA_FIELD_WIDTH-1:0]      ld_data,
  output logic                             done,
  output logic                             err
);

  localparam int c_IDX_W = $clog2(VLEN);
  localparam int c_LEN_W = c_IDX_W + 1;
  localparam int c_BE_W  = DATA_FIELD_WIDTH / BYTE;
  localparam logic [CORE_ID_WIDTH-1:0] c_CORE = CORE_ID_WIDTH'(CORE_ID);

  vmr_state_e                  r_state;
  vmr_state_e                  w_state_next;
  logic                        r_store;
  logic [ADDR_FIELD_WIDTH-1:0] r_stride;
  logic [c_LEN_W-1:0]          r_len;
  logic [c_BE_W-1:0]           r_byte_en;
  logic [c_LEN_W-1:0]          r_i;
  logic [c_LEN_W-1:0]          r_r;
  logic                        r_err;
  request_t                    r_mem_req;
  request_t                    w_req_d;
  logic                        r_ld_vld;
  logic [c_IDX_W-1:0]          r_ld_idx;
  logic [DATA_FIELD_WIDTH-1:0] r_ld_data;

  logic                        w_accept;
  logic                        w_busy;
  logic [c_LEN_W-1:0]          w_i_inc;
  logic [c_LEN_W-1:0]          w_next_idx;
  logic                        w_next_store;
  logic                        w_rsp_acc;
  logic                        w_r_inc;
  logic [c_LEN_W-1:0]          w_r_next;
  logic                        w_aid_oob;
  logic                        w_type_bad;
  logic                        w_err_d;
  logic                        w_ld_vld_d;
  logic [c_IDX_W-1:0]          w_ld_idx_d;
  logic [DATA_FIELD_WIDTH-1:0] w_ld_data_d;
  logic                        w_unused_rsp;

  assign w_accept   = cmd_vld && (r_state == IDLE);
  assign w_busy     = (r_state == ISSUE) || (r_state == DRAIN);
  assign w_i_inc    = r_i + c_LEN_W'(1);
  assign w_rsp_acc  = mem_rsp.vld && (mem_rsp.core_id == c_CORE);
  assign w_r_inc    = w_rsp_acc && w_busy;
  assign w_r_next   = r_r + c_LEN_W'(w_r_inc);
  assign w_aid_oob  = 32'(mem_rsp.access_id) >= 32'(r_len);
  assign w_type_bad = mem_rsp.access_type != (r_store ? WRITE_RSP : READ_RSP);
  assign w_err_d    = w_rsp_acc && ((r_state == IDLE) || w_aid_oob || w_type_bad);
  assign w_unused_rsp = ^{mem_rsp.addr, mem_rsp.byte_en};

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (cmd_vld) w_state_next = (cmd_len == '0) ? DONE : ISSUE;
      ISSUE:   if (w_i_inc == r_len) w_state_next = DRAIN;
      DRAIN:   if (w_r_next >= r_len) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // mem_req is registered, so store data is fetched for the element about to be latched
  always_comb begin
    cmd_rdy = (r_state == IDLE);
    done    = (r_state == DONE);
    st_idx  = (r_state == ISSUE) ? w_i_inc[c_IDX_W-1:0] : '0;
  end

  always_comb begin
    w_req_d      = '0;
    w_next_idx   = (r_state == IDLE) ? '0 : w_i_inc;
    w_next_store = (r_state == IDLE) ? cmd_store : r_store;
    if (w_state_next == ISSUE) begin
      w_req_d.vld         = 1'b1;
      w_req_d.core_id     = c_CORE;
      w_req_d.access_id   = ACCESS_ID_WIDTH'(w_next_idx);
      w_req_d.access_type = w_next_store ? WRITE_REQ : READ_REQ;
      w_req_d.addr        = (r_state == IDLE) ? cmd_base : (r_mem_req.addr + r_stride);
      w_req_d.data        = w_next_store ? st_data : '0;
      w_req_d.byte_en     = (r_state == IDLE) ? cmd_byte_en : r_byte_en;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_store   <= 1'b0;
      r_stride  <= '0;
      r_len     <= '0;
      r_byte_en <= '0;
      r_i       <= '0;
      r_r       <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store   <= cmd_store;
        r_stride  <= cmd_stride;
        r_len     <= cmd_len;
        r_byte_en <= cmd_byte_en;
        r_i       <= '0;
        r_r       <= '0;
      end else begin
        if (r_state == ISSUE) r_i <= w_i_inc;
        if (w_r_inc)          r_r <= w_r_next;
      end
      r_err <= r_err | w_err_d;
    end
  end

  assign w_ld_vld_d  = w_r_inc && (mem_rsp.access_type == READ_RSP);
  assign w_ld_idx_d  = w_ld_vld_d ? mem_rsp.access_id[c_IDX_W-1:0] : r_ld_idx;
  assign w_ld_data_d = w_ld_vld_d ? mem_rsp.data : r_ld_data;

  `FLIP_FLOP(r_mem_req, w_req_d, '0)
  `FLIP_FLOP(r_ld_vld, w_ld_vld_d, 1'b0)
  `FLIP_FLOP(r_ld_idx, w_ld_idx_d, '0)
  `FLIP_FLOP(r_ld_data, w_ld_data_d, '0)

  assign mem_req = r_mem_req;
  assign ld_vld  = r_ld_vld;
  assign ld_idx  = r_ld_idx;
  assign ld_data = r_ld_data;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_requester.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vector_mem_requester : directed checks against a 2-cycle memory model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_vector_mem_requester;
  import vector_mem_requester_pkg::*;

  localparam int c_VLEN = 64;
  localparam int c_CORE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_store;
  logic [31:0] cmd_base;
  logic [31:0] cmd_stride;
  logic [6:0]  cmd_len;
  logic [3:0]  cmd_byte_en;
  logic [5:0]  st_idx;
  logic [31:0] st_data;
  request_t    mem_req;
  request_t    mem_rsp;
  logic        ld_vld;
  logic [5:0]  ld_idx;
  logic [31:0] ld_data;
  logic        done;
  logic        err;

  request_t pipe1 = '0;
  request_t pipe2 = '0;
  request_t inj_rsp = '0;
  request_t no_inj = '0;
  request_t tmp_rsp;
  logic     inj_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] req_addr [16];
  logic [31:0] req_data [16];
  logic [1:0]  req_type [16];
  logic [7:0]  req_aid  [16];
  logic [3:0]  req_core [16];
  logic [3:0]  req_be   [16];
  int          req_k    [16];
  logic [5:0]  ldi      [16];
  logic [31:0] ldd      [16];
  int          n_req, n_ld, n_done, done_k;
  logic        err_inj, rdy_after;

  vector_mem_requester #(.CORE_ID(c_CORE), .VLEN(c_VLEN)) dut (
    .clk(clk), .reset(reset), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_store(cmd_store), .cmd_base(cmd_base), .cmd_stride(cmd_stride),
    .cmd_len(cmd_len), .cmd_byte_en(cmd_byte_en), .st_idx(st_idx),
    .st_data(st_data), .mem_req(mem_req), .mem_rsp(mem_rsp),
    .ld_vld(ld_vld), .ld_idx(ld_idx), .ld_data(ld_data),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign st_data = 32'(st_idx) * 32'h11;
  assign mem_rsp = inj_en ? inj_rsp : pipe2;

  function automatic request_t mem_model(input request_t q);
    request_t r;
    r = q;
    if (q.vld) begin
      r.access_type = (q.access_type == WRITE_REQ) ? WRITE_RSP : READ_RSP;
      r.data = (q.access_type == WRITE_REQ) ? 32'h0 : {16'hD000, q.addr[15:0]};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    pipe1 <= mem_req;
    pipe2 <= mem_model(pipe1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic store, input logic [31:0] base, input logic [31:0] stride,
                         input logic [6:0] len, input logic [3:0] be,
                         input int inj_at, input request_t inj);
    n_req = 0; n_ld = 0; n_done = 0; done_k = -1; err_inj = 1'b0; rdy_after = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_addr[i] = '0; req_data[i] = '0; req_type[i] = '0; req_aid[i] = '0;
      req_core[i] = '0; req_be[i] = '0; req_k[i] = 0; ldi[i] = '0; ldd[i] = '0;
    end
    @(negedge clk);
    cmd_vld = 1'b1; cmd_store = store; cmd_base = base; cmd_stride = stride;
    cmd_len = len; cmd_byte_en = be;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) cmd_vld = 1'b0;
      if (mem_req.vld && n_req < 16) begin
        req_addr[n_req] = mem_req.addr; req_data[n_req] = mem_req.data;
        req_type[n_req] = mem_req.access_type; req_aid[n_req] = mem_req.access_id;
        req_core[n_req] = mem_req.core_id; req_be[n_req] = mem_req.byte_en;
        req_k[n_req] = k; n_req++;
      end
      if (ld_vld && n_ld < 16) begin
        ldi[n_ld] = ld_idx; ldd[n_ld] = ld_data; n_ld++;
      end
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (k == inj_at + 1) err_inj = err;
      if (k == inj_at) begin inj_rsp = inj; inj_en = 1'b1; end
      else inj_en = 1'b0;
      if (done_k >= 0 && k >= done_k + 2) begin
        rdy_after = cmd_rdy;
        break;
      end
    end
    if (done_k < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reqs(input string tag, input int n, input logic [31:0] base,
                            input logic [31:0] stride, input logic store, input logic [3:0] be);
    logic [31:0] a;
    a = base;
    check({tag, "_nreq"}, 64'(n_req), 64'(n));
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 64'(req_addr[i]), 64'(a));
      check({tag, "_k"}, 64'(req_k[i]), 64'(i + 1));
      check({tag, "_aid"}, 64'(req_aid[i]), 64'(i));
      check({tag, "_type"}, 64'(req_type[i]), store ? 64'(WRITE_REQ) : 64'(READ_REQ));
      check({tag, "_data"}, 64'(req_data[i]), store ? 64'(i * 32'h11) : 64'd0);
      check({tag, "_core"}, 64'(req_core[i]), 64'(c_CORE));
      check({tag, "_be"}, 64'(req_be[i]), 64'(be));
      a = a + stride;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cmd_vld = 1'b0; cmd_store = 1'b0; cmd_base = '0;
    cmd_stride = '0; cmd_len = '0; cmd_byte_en = '0;
    repeat (3) @(negedge clk);
    check("rst_rdy", 64'(cmd_rdy), 64'd1);
    check("rst_req", 64'(mem_req == '0), 64'd1);
    check("rst_ldvld", 64'(ld_vld), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_stidx", 64'(st_idx), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Load, base 0x100 stride 4 len 4
    run_cmd(1'b0, 32'h100, 32'd4, 7'd4, 4'hF, -1, no_inj);
    check_reqs("ld", 4, 32'h100, 32'd4, 1'b0, 4'hF);
    check("ld_nld", 64'(n_ld), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("ld_idx", 64'(ldi[i]), 64'(i));
      check("ld_data", 64'(ldd[i]), 64'(32'hD000_0100 + 32'(4 * i)));
    end
    check("ld_ndone", 64'(n_done), 64'd1);
    check("ld_donek", 64'(done_k), 64'd7);
    check("ld_rdy", 64'(rdy_after), 64'd1);
    check("ld_err", 64'(err), 64'd0);

    // Store, len 3, st_data = idx*0x11
    run_cmd(1'b1, 32'h200, 32'd8, 7'd3, 4'h3, -1, no_inj);
    check_reqs("st", 3, 32'h200, 32'd8, 1'b1, 4'h3);
    check("st_nld", 64'(n_ld), 64'd0);
    check("st_ndone", 64'(n_done), 64'd1);
    check("st_donek", 64'(done_k), 64'd6);
    check("st_err", 64'(err), 64'd0);

    // Negative stride wraps below zero
    run_cmd(1'b0, 32'h4, 32'hFFFF_FFFC, 7'd3, 4'hF, -1, no_inj);
    check("neg_nreq", 64'(n_req), 64'd3);
    check("neg_a0", 64'(req_addr[0]), 64'h4);
    check("neg_a1", 64'(req_addr[1]), 64'h0);
    check("neg_a2", 64'(req_addr[2]), 64'hFFFF_FFFC);
    check("neg_d2", 64'(ldd[2]), 64'hD000_FFFC);
    check("neg_donek", 64'(done_k), 64'd6);

    // Zero-length command
    run_cmd(1'b0, 32'h0, 32'd4, 7'd0, 4'hF, -1, no_inj);
    check("z_nreq", 64'(n_req), 64'd0);
    check("z_donek", 64'(done_k), 64'd1);
    check("z_ndone", 64'(n_done), 64'd1);
    check("z_rdy", 64'(rdy_after), 64'd1);

    // Foreign core response while idle is ignored
    @(negedge clk);
    tmp_rsp = '0;
    tmp_rsp.vld = 1'b1; tmp_rsp.core_id = 4'd5; tmp_rsp.access_type = READ_RSP;
    inj_rsp = tmp_rsp; inj_en = 1'b1;
    @(negedge clk);
    inj_en = 1'b0;
    check("foreign_err", 64'(err), 64'd0);

    // Out-of-range access_id sets sticky err
    tmp_rsp.core_id = 4'(c_CORE); tmp_rsp.access_id = 8'd5;
    run_cmd(1'b0, 32'h100, 32'd4, 7'd4, 4'hF, 1, tmp_rsp);
    check("oob_err", 64'(err_inj), 64'd1);
    repeat (3) @(negedge clk);
    check("oob_sticky", 64'(err), 64'd1);

    // Reset in the middle of ISSUE
    @(negedge clk);
    cmd_vld = 1'b1; cmd_store = 1'b0; cmd_base = 32'h300; cmd_stride = 32'd4;
    cmd_len = 7'd8; cmd_byte_en = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_vld", 64'(mem_req.vld), 64'd1);
    check("mid_addr", 64'(mem_req.addr), 64'h308);
    reset = 1'b0;
    #1;
    check("arst_req", 64'(mem_req == '0), 64'd1);
    check("arst_rdy", 64'(cmd_rdy), 64'd1);
    check("arst_err", 64'(err), 64'd0);
    check("arst_stidx", 64'(st_idx), 64'd0);
    check("arst_ld", 64'({ld_vld, ld_idx, ld_data}), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_err", 64'(err), 64'd0);
    run_cmd(1'b0, 32'h40, 32'h10, 7'd2, 4'hF, -1, no_inj);
    check_reqs("post", 2, 32'h40, 32'h10, 1'b0, 4'hF);
    check("post_nld", 64'(n_ld), 64'd2);
    check("post_donek", 64'(done_k), 64'd5);
    check("post_err", 64'(err), 64'd0);

    // Late response arriving in IDLE
    @(negedge clk);
    tmp_rsp = '0;
    tmp_rsp.vld = 1'b1; tmp_rsp.core_id = 4'(c_CORE); tmp_rsp.access_type = READ_RSP;
    inj_rsp = tmp_rsp; inj_en = 1'b1;
    @(negedge clk);
    inj_en = 1'b0;
    check("late_err", 64'(err), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vector_mem_requester.md
VECTOR_MEM_REQUESTER -- requirements
Module: vector_mem_requester

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, core_id stamped on every request and matched on responses.
REQ-002 SHALL have parameter VLEN, default 64, maximum elements per command.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_vld  input  1  command valid.
REQ-006 SHALL have port cmd_rdy  output  1  block idle, command accepted when cmd_vld&&cmd_rdy.
REQ-007 SHALL have port cmd_store  input  1  1=store (WRITE_REQ), 0=load (READ_REQ).
REQ-008 SHALL have port cmd_base  input  ADDR_FIELD_WIDTH  element-0 address.
REQ-009 SHALL have port cmd_stride  input  ADDR_FIELD_WIDTH  signed two's-complement address step.
REQ-010 SHALL have port cmd_len  input  $clog2(VLEN)+1  element count, 0..VLEN.
REQ-011 SHALL have port cmd_byte_en  input  DATA_FIELD_WIDTH/BYTE  byte enables for every element.
REQ-012 SHALL have port st_idx  output  $clog2(VLEN)  element index of store data needed this cycle.
REQ-013 SHALL have port st_data  input  DATA_FIELD_WIDTH  store data for st_idx, same-cycle combinational return.
REQ-014 SHALL have port mem_req  output  request_t  request to memory controller.
REQ-015 SHALL have port mem_rsp  input  request_t  response from memory controller.
REQ-016 SHALL have ports ld_vld/ld_idx/ld_data  output  1/$clog2(VLEN)/DATA_FIELD_WIDTH  load-element writeback.
REQ-017 SHALL have port done  output  1  one-cycle pulse when command complete.
REQ-018 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE; cmd_rdy=1 only in IDLE.
REQ-020 SHALL on accept latch command, clear issue count i and response count r; cmd_len=0 goes IDLE->DONE, no requests.
REQ-021 SHALL in ISSUE drive registered mem_req one element per cycle, no backpressure: vld=1, core_id=CORE_ID, access_id=i, addr=base+i*stride modulo 2^ADDR_FIELD_WIDTH (running-sum adder, no multiplier), byte_en=cmd_byte_en.
REQ-022 SHALL for stores set access_type=WRITE_REQ, data=st_data with st_idx=i; for loads access_type=READ_REQ, data=0.
REQ-023 SHALL leave ISSUE after element cmd_len-1; mem_req.vld=0 outside ISSUE.
REQ-024 SHALL accept mem_rsp only when vld=1 and core_id==CORE_ID; others ignored silently.
REQ-025 SHALL on accepted READ_RSP assert ld_vld next cycle with ld_idx=access_id, ld_data=mem_rsp.data; WRITE_RSP produces no ld_vld.
REQ-026 SHALL increment r per accepted response; DRAIN->DONE when r reaches cmd_len (responses may arrive during ISSUE).
REQ-027 SHALL pulse done for exactly the DONE cycle; nominal latency accept->done = cmd_len+3 cycles for 2-cycle memory.
REQ-028 SHALL set err on accepted response in IDLE, access_id>=cmd_len, or response type mismatching command; err cleared only by reset.
REQ-029 SHALL ignore cmd_vld while busy (no queuing).

Reset
REQ-030 SHALL on reset low force FSM=IDLE, cmd_rdy=1, mem_req all-zero, ld_vld=0, ld_idx=0, ld_data=0, done=0, err=0, st_idx=0, counters=0, immediately (asynchronous).
REQ-031 SHALL abandon any in-flight command on mid-operation reset; late responses after reset in IDLE set err.

Structure
REQ-032 SHALL take request_t, READ_REQ/WRITE_REQ/READ_RSP/WRITE_RSP, ADDR_FIELD_WIDTH, DATA_FIELD_WIDTH, BYTE from the shared package; FSM state enum also declared there.
REQ-033 SHALL use the codebase flip_flop macro for pipeline registers; no sub-module required.

Verification
REQ-034 SHALL test load base=0x100, stride=4, len=4 -> addrs 0x100,0x104,0x108,0x10C on consecutive cycles; ld_idx 0..3 with memory data; done at cycle 7.
REQ-035 SHALL test store len=3, st_data=idx*0x11 -> WRITE_REQ data 0x00,0x11,0x22; no ld_vld; done once.
REQ-036 SHALL test negative stride -4 from base=0x4 -> addrs 0x4,0x0,wrap to all-ones minus 3.
REQ-037 SHALL test cmd_len=0 -> no mem_req.vld, done one cycle after accept, cmd_rdy back to 1.
REQ-038 SHALL test foreign core_id response ignored; response with access_id=5 on len=4 -> err=1 sticky.
REQ-039 SHALL test reset asserted mid-ISSUE -> outputs zero immediately, cmd_rdy=1, next command runs cleanly.
